// File: rtl/mef_tx.sv
// mef_tx: serial frame transmitter for a zero-run detector.
// A frame is PRE_LEN zeros, a '1' marker, DATA_W payload bits MSB first, then
// GAP_LEN ones. A '1' is stuffed after every STUFF_RUN consecutive payload zeros,
// so the only zero run that can reach PRE_LEN is the preamble.
// Optional feature macro: MEF_TX_PARITY_EN appends an even-parity bit after the
// data bits. That bit counts as payload for stuffing.
module mef_tx #(
  parameter int DATA_W    = 8,
  parameter int PRE_LEN   = 4,
  parameter int STUFF_RUN = 3,
  parameter int GAP_LEN   = 1
) (
  input  logic              CLK,
  input  logic              CLR_N,
  input  logic              VALID,
  input  logic [DATA_W-1:0] DATA,
  output logic              READY,
  output logic              E,
  output logic              BUSY,
  output logic              DONE
);

  localparam int MAX_A = (PRE_LEN > DATA_W) ? PRE_LEN : DATA_W;
  localparam int MAX_B = (MAX_A > GAP_LEN) ? MAX_A : GAP_LEN;
  localparam int MAX_C = (MAX_B > STUFF_RUN) ? MAX_B : STUFF_RUN;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_LEN - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0] STUFF_LIM = CW'(STUFF_RUN);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_MARK = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
`ifdef MEF_TX_PARITY_EN
  localparam logic [2:0] S_PAR  = 3'd5;
`endif

  logic [2:0]        r_state, w_state;
  logic              r_e, w_e;
  logic              r_busy;
  logic              r_done, w_done;
  logic [CW-1:0]     r_cnt, w_cnt;    // preamble/gap cycle count, or data bits left
  logic [CW-1:0]     r_zrun, w_zrun;  // consecutive payload zeros already on the line
  logic [DATA_W-1:0] r_sr, w_sr;
`ifdef MEF_TX_PARITY_EN
  logic              r_par, w_par;
`endif
  logic              w_ready;

  assign w_ready = (r_state == S_IDLE) && CLR_N;
  assign READY   = w_ready;
  assign E       = r_e;
  assign BUSY    = r_busy;
  assign DONE    = r_done;

  // Next-state logic: decides the line bit for the coming cycle.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    w_state = r_state;
    w_e     = r_e;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    w_zrun  = r_zrun;
    w_sr    = r_sr;
`ifdef MEF_TX_PARITY_EN
    w_par   = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_e = 1'b1;
        if (VALID && w_ready) begin
          w_state = S_PRE;
          w_e     = 1'b0;
          w_cnt   = '0;
          w_zrun  = '0;
          w_sr    = DATA;
`ifdef MEF_TX_PARITY_EN
          w_par   = ^DATA;
`endif
        end
      end
      S_PRE: begin
        if (r_cnt == PRE_LAST) begin
          w_state = S_MARK;
          w_e     = 1'b1;
          w_cnt   = '0;
        end else begin
          w_e   = 1'b0;
          w_cnt = r_cnt + 1'b1;
        end
      end
      S_MARK: begin
        // The marker clears the zero run; the first data bit goes out next.
        w_state = S_DATA;
        w_e     = r_sr[DATA_W-1];
        w_sr    = r_sr << 1;
        w_cnt   = DATA_LAST;
        w_zrun  = r_sr[DATA_W-1] ? '0 : CW'(1);
      end
      S_DATA: begin
        if (r_zrun == STUFF_LIM) begin
          // Stuffed '1': data bit index and shift register hold.
          w_e    = 1'b1;
          w_zrun = '0;
        end else if (r_cnt != '0) begin
          w_e    = r_sr[DATA_W-1];
          w_sr   = r_sr << 1;
          w_cnt  = r_cnt - 1'b1;
          w_zrun = r_sr[DATA_W-1] ? '0 : r_zrun + 1'b1;
        end else begin
`ifdef MEF_TX_PARITY_EN
          w_state = S_PAR;
          w_e     = r_par;
          w_zrun  = r_par ? '0 : r_zrun + 1'b1;
`else
          w_state = S_GAP;
          w_e     = 1'b1;
          w_cnt   = '0;
          w_zrun  = '0;
`endif
        end
      end
`ifdef MEF_TX_PARITY_EN
      S_PAR: begin
        // Parity bit is on the line; it may still need a stuffed '1' after it.
        if (r_zrun == STUFF_LIM) begin
          w_e    = 1'b1;
          w_zrun = '0;
        end else begin
          w_state = S_GAP;
          w_e     = 1'b1;
          w_cnt   = '0;
          w_zrun  = '0;
        end
      end
`endif
      S_GAP: begin
        w_e = 1'b1;
        if (r_cnt == GAP_LAST) begin
          w_state = S_IDLE;
          w_done  = 1'b1;
          w_cnt   = '0;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state = S_IDLE;
        w_e     = 1'b1;
        w_cnt   = '0;
        w_zrun  = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!CLR_N) begin
      r_state <= S_IDLE;
      r_e     <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_zrun  <= '0;
      r_sr    <= '0;
`ifdef MEF_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_e     <= w_e;
      r_busy  <= (w_state != S_IDLE);
      r_done  <= w_done;
      r_cnt   <= w_cnt;
      r_zrun  <= w_zrun;
      r_sr    <= w_sr;
`ifdef MEF_TX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

endmodule

// File: tb/tb_mef_tx.sv
// tb_mef_tx: self-checking bench for mef_tx (default parameters).
// The expected line sequence of each frame is built from the frame rules
// (preamble, marker, stuffed payload, gap). Outputs are sampled on the falling
// edge, and inputs are also driven there.
module tb_mef_tx;

  localparam int DATA_W    = 8;
  localparam int PRE_LEN   = 4;
  localparam int STUFF_RUN = 3;
  localparam int GAP_LEN   = 1;

  logic              CLK;
  logic              CLR_N;
  logic              VALID;
  logic [DATA_W-1:0] DATA;
  logic              READY;
  logic              E;
  logic              BUSY;
  logic              DONE;

  int tests;
  int fails;
  bit exp_q[$];

  mef_tx #(
    .DATA_W   (DATA_W),
    .PRE_LEN  (PRE_LEN),
    .STUFF_RUN(STUFF_RUN),
    .GAP_LEN  (GAP_LEN)
  ) dut (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .VALID(VALID),
    .DATA (DATA),
    .READY(READY),
    .E    (E),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: list of line bits for one frame, derived from the framing rules.
  task automatic build_exp(input logic [DATA_W-1:0] d);
    bit payload[$];
    int run;
    exp_q.delete();
    for (int i = 0; i < PRE_LEN; i++) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int i = DATA_W - 1; i >= 0; i--) payload.push_back(d[i]);
`ifdef MEF_TX_PARITY_EN
    payload.push_back(^d);
`endif
    run = 0;
    foreach (payload[i]) begin
      exp_q.push_back(payload[i]);
      run = payload[i] ? 0 : run + 1;
      if (run == STUFF_RUN) begin
        exp_q.push_back(1'b1);
        run = 0;
      end
    end
    for (int i = 0; i < GAP_LEN; i++) exp_q.push_back(1'b1);
  endtask

  // Sends one frame starting at a falling edge with the DUT idle and checks
  // every line bit, BUSY, DONE and the detector pulse count. Returns at the
  // falling edge of the IDLE cycle that carries DONE.
  task automatic run_frame(input logic [DATA_W-1:0] d, input string name, input bit keep_valid);
    int zr;
    int ycnt;
    build_exp(d);
    tests++;
    if (READY !== 1'b1) begin
      fails++;
      $display("FAIL %s ready_before got %b exp 1", name, READY);
    end
    VALID = 1'b1;
    DATA  = d;
    @(negedge CLK);
    zr   = 0;
    ycnt = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      tests++;
      if (E !== exp_q[i] || BUSY !== 1'b1 || DONE !== 1'b0) begin
        fails++;
        $display("FAIL %s bit%0d got E=%b BUSY=%b DONE=%b exp E=%b BUSY=1 DONE=0",
                 name, i, E, BUSY, DONE, exp_q[i]);
      end
      if (E === 1'b0) begin
        zr++;
        if (zr == PRE_LEN) ycnt++;
      end else begin
        zr = 0;
      end
      // Inputs while busy must be ignored.
      VALID = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
      DATA  = DATA_W'($urandom);
      @(negedge CLK);
    end
    tests++;
    if (E !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b1 || READY !== 1'b1) begin
      fails++;
      $display("FAIL %s frame_end got E=%b BUSY=%b DONE=%b READY=%b exp 1 0 1 1",
               name, E, BUSY, DONE, READY);
    end
    tests++;
    if (ycnt !== 1) begin
      fails++;
      $display("FAIL %s detector_pulses got %0d exp 1", name, ycnt);
    end
    if (!keep_valid) VALID = 1'b0;
  endtask

  task automatic idle_cycle(input string name);
    @(negedge CLK);
    tests++;
    if (DONE !== 1'b0 || E !== 1'b1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL %s idle got DONE=%b E=%b BUSY=%b exp 0 1 0", name, DONE, E, BUSY);
    end
  endtask

  task automatic test_reset();
    CLR_N = 1'b0;
    VALID = 1'b0;
    DATA  = '0;
    repeat (3) @(negedge CLK);
    tests++;
    if (E !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || READY !== 1'b0) begin
      fails++;
      $display("FAIL reset_hold got E=%b BUSY=%b DONE=%b READY=%b exp 1 0 0 0",
               E, BUSY, DONE, READY);
    end
    CLR_N = 1'b1;
    @(negedge CLK);
    tests++;
    if (READY !== 1'b1 || E !== 1'b1 || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL reset_release got READY=%b E=%b BUSY=%b exp 1 1 0", READY, E, BUSY);
    end
  endtask

  task automatic test_directed();
    run_frame(8'hA5, "frame_a5", 1'b0);
    idle_cycle("after_a5");
    run_frame(8'h00, "frame_00", 1'b0);
    idle_cycle("after_00");
    run_frame(8'h10, "frame_10", 1'b0);
    idle_cycle("after_10");
    run_frame(8'h08, "frame_08_tail_stuff", 1'b0);
    idle_cycle("after_08");
    run_frame(8'hFF, "frame_ff", 1'b0);
    idle_cycle("after_ff");
  endtask

  task automatic test_abort();
    build_exp(8'hA5);
    VALID = 1'b1;
    DATA  = 8'hA5;
    @(negedge CLK);
    VALID = 1'b0;
    // Cycles 0..3 preamble, 4 marker, 5..7 first three data bits.
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (E !== exp_q[i]) begin
        fails++;
        $display("FAIL abort_pre bit%0d got %b exp %b", i, E, exp_q[i]);
      end
      if (i < 7) @(negedge CLK);
    end
    CLR_N = 1'b0;
    @(negedge CLK);
    tests++;
    if (E !== 1'b1 || BUSY !== 1'b0 || DONE !== 1'b0 || READY !== 1'b0) begin
      fails++;
      $display("FAIL abort_reset got E=%b BUSY=%b DONE=%b READY=%b exp 1 0 0 0",
               E, BUSY, DONE, READY);
    end
    CLR_N = 1'b1;
    @(negedge CLK);
    tests++;
    if (READY !== 1'b1 || DONE !== 1'b0 || E !== 1'b1) begin
      fails++;
      $display("FAIL abort_release got READY=%b DONE=%b E=%b exp 1 0 1", READY, DONE, E);
    end
    run_frame(8'hA5, "abort_refill", 1'b0);
    idle_cycle("after_abort");
  endtask

  task automatic test_back_to_back();
    run_frame(8'hFF, "b2b_ff", 1'b1);
    run_frame(8'h81, "b2b_81", 1'b0);
    idle_cycle("after_b2b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      run_frame(DATA_W'($urandom), "random", 1'b0);
      if ($urandom_range(0, 1) == 1) idle_cycle("random_idle");
      else begin
        // Occasionally start the next frame straight from the DONE cycle.
        run_frame(DATA_W'($urandom), "random_b2b", 1'b0);
        idle_cycle("random_idle2");
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    CLR_N = 1'b0;
    VALID = 1'b0;
    DATA  = '0;
    test_reset();
    test_directed();
    test_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
